cpu_ma: RTL

Risc-V CPU memory-access stage, directly downstream of the execution stage and upstream of write-back. It consumes the EX pipeline registers, performs aligned loads and stores over a registered request/acknowledge data-memory port, and lane-selects plus sign- or zero-extends load data. It stalls the upstream pipeline while a memory transaction is outstanding, and it exposes async write-back signals for forwarding and hazard detection.

---
 rtl/common.sv | 19 +
 rtl/cpu_ma.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/common.sv
// Shared pipeline types and NOP constants for the RISC-V core stages.
package common;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regaddr_t;

    typedef enum logic [1:0] {MA_X, MA_LOAD, MA_STORE} ma_mode_t;

    typedef enum logic [2:0] {
        MA_SIZE_B, MA_SIZE_H, MA_SIZE_W, MA_SIZE_BU, MA_SIZE_HU
    } ma_size_t;

    typedef enum logic [1:0] {WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC, WB_SRC_IMM} wb_src_t;

    localparam word_t NOP_PC       = 32'h0000_0000;
    localparam word_t NOP_IR       = 32'h0000_0013;
    localparam logic  NOP_WB_VALID = 1'b0;

endpackage

// File: rtl/cpu_ma.sv
// Memory-access stage: aligned loads/stores over a req/ack data port, stalling EX
// while a transaction is outstanding and exposing async write-back for forwarding.
module cpu_ma
    import common::*;
(
    input  logic     clk_i,
    input  logic     reset_i,
    input  word_t    pc_i,
    input  word_t    ir_i,
    input  word_t    ma_addr_i,
    input  ma_mode_t ma_mode_i,
    input  ma_size_t ma_size_i,
    input  word_t    ma_data_i,
    input  wb_src_t  wb_src_i,
    input  word_t    wb_data_i,
    input  logic     wb_valid_i,
    output word_t    dmem_addr_o,
    output logic     dmem_req_o,
    output logic [3:0] dmem_we_o,
    output word_t    dmem_wdata_o,
    input  word_t    dmem_rdata_i,
    input  logic     dmem_ack_i,
    output logic     stall_async_o,
    output regaddr_t wb_addr_async_o,
    output word_t    wb_data_async_o,
    output logic     wb_ready_async_o,
    output logic     wb_valid_async_o,
    output logic     empty_async_o,
    output word_t    pc_o,
    output word_t    ir_o,
    output word_t    wb_data_o,
    output logic     wb_valid_o,
    output logic     misaligned_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e     state_q, state_d;
    logic       req_q, req_d;
    logic [3:0] we_q, we_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;
    word_t      load_q, load_d;
    word_t      pc_q, pc_d;
    word_t      ir_q, ir_d;
    word_t      wbd_q, wbd_d;
    logic       wbv_q, wbv_d;
    logic       mis_q, mis_d;

    logic       is_mem;
    logic       is_load;
    logic       misaligned;
    logic [3:0] we_calc;
    word_t      wdata_calc;
    word_t      load_ext;
    word_t      byte_lane;
    word_t      half_lane;
    logic       stall;

    assign is_mem  = (ma_mode_i != MA_X);
    assign is_load = (ma_mode_i == MA_LOAD);

    always_comb begin
        misaligned = 1'b0;
        if (is_mem) begin
            unique case (ma_size_i)
                MA_SIZE_H, MA_SIZE_HU: misaligned = ma_addr_i[0];
                MA_SIZE_W:             misaligned = (ma_addr_i[1:0] != 2'b00);
                default:               misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        we_calc    = 4'b0000;
        wdata_calc = ma_data_i;
        unique case (ma_size_i)
            MA_SIZE_B, MA_SIZE_BU: begin
                we_calc    = 4'b0001 << ma_addr_i[1:0];
                wdata_calc = {4{ma_data_i[7:0]}};
            end
            MA_SIZE_H, MA_SIZE_HU: begin
                we_calc    = 4'b0011 << {ma_addr_i[1], 1'b0};
                wdata_calc = {2{ma_data_i[15:0]}};
            end
            MA_SIZE_W: we_calc = 4'b1111;
            default:   we_calc = 4'b0000;
        endcase
        if (is_load) begin
            we_calc = 4'b0000;
        end
    end

    // Inputs are held stable while stalled, so the lane offset is taken from ma_addr_i.
    assign byte_lane = dmem_rdata_i >> {ma_addr_i[1:0], 3'b000};
    assign half_lane = dmem_rdata_i >> {ma_addr_i[1], 4'b0000};

    always_comb begin
        load_ext = dmem_rdata_i;
        unique case (ma_size_i)
            MA_SIZE_B:  load_ext = {{24{byte_lane[7]}}, byte_lane[7:0]};
            MA_SIZE_BU: load_ext = {24'h0, byte_lane[7:0]};
            MA_SIZE_H:  load_ext = {{16{half_lane[15]}}, half_lane[15:0]};
            MA_SIZE_HU: load_ext = {16'h0, half_lane[15:0]};
            default:    load_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        pc_d    = NOP_PC;
        ir_d    = NOP_IR;
        wbd_d   = '0;
        wbv_d   = NOP_WB_VALID;
        mis_d   = 1'b0;
        stall   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_mem && !misaligned) begin
                    stall   = 1'b1;
                    state_d = StBusy;
                    req_d   = 1'b1;
                    addr_d  = {ma_addr_i[31:2], 2'b00};
                    we_d    = we_calc;
                    wdata_d = wdata_calc;
                end else begin
                    pc_d  = pc_i;
                    ir_d  = ir_i;
                    wbd_d = wb_data_i;
                    wbv_d = misaligned ? 1'b0 : wb_valid_i;
                    mis_d = misaligned;
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (dmem_ack_i) begin
                    req_d   = 1'b0;
                    we_d    = 4'b0000;
                    load_d  = load_ext;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                pc_d    = pc_i;
                ir_d    = ir_i;
                wbd_d   = is_load ? load_q : wb_data_i;
                wbv_d   = wb_valid_i;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            pc_q    <= NOP_PC;
            ir_q    <= NOP_IR;
            wbd_q   <= '0;
            wbv_q   <= NOP_WB_VALID;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wbd_q   <= wbd_d;
            wbv_q   <= wbv_d;
            mis_q   <= mis_d;
        end
    end

    assign dmem_addr_o  = addr_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_wdata_o = wdata_q;
    assign pc_o         = pc_q;
    assign ir_o         = ir_q;
    assign wb_data_o    = wbd_q;
    assign wb_valid_o   = wbv_q;
    assign misaligned_o = mis_q;

    assign stall_async_o    = stall;
    assign wb_addr_async_o  = ir_i[11:7];
    assign wb_data_async_o  = (state_q == StDone && is_load) ? load_q : wb_data_i;
    assign wb_ready_async_o = (wb_src_i != WB_SRC_MEM) || (state_q == StDone);
    assign wb_valid_async_o = wb_valid_i;
    assign empty_async_o    = (pc_i == NOP_PC);

endmodule
